wrr_sched_param: RTL and testbench
==================================

// Module: wrr_sched_param
// PURPOSE
//  Parametrised weighted-round-robin scheduler, next generation of the 4-VC WRR block.
//  Arbitrates N_VC virtual channels and forwards one DATA_W word per cycle from the granted VC.
//  Burst length per visit equals that VC's programmed weight; the scheduler is work-conserving.
//  Adds over the fixed 4-VC version: idle-VC skipping, weight-0 disable, runtime weight edit
//  with defined mid-burst semantics, and an explicit per-VC request/grant handshake.
// PARAMETERS
//  N_VC     4   number of virtual channels (>=2)
//  W_WIDTH  3   weight width in bits; burst length is 1..2**W_WIDTH-1
//  DATA_W   4   data word width
//  VC_W     2   index width, must equal clog2(N_VC)
// PORTS
//  CLK_2MHz       in   1               scheduler clock
//  reset          in   1               async, active-low
//  req            in   N_VC            VC i holds a word on data_in slice i
//  data_in        in   N_VC*DATA_W     VC i word at [i*DATA_W +: DATA_W]
//  edit_weight    in   1               write weight_assign into weight[vc_assign] at the edge
//  vc_assign      in   VC_W            target VC of a weight write
//  weight_assign  in   W_WIDTH         new weight value
//  grant          out  N_VC            registered one-hot; bit i = word of VC i taken at that edge
//  grant_vc       out  VC_W            index of granted VC (valid when valid_out)
//  Data_Word      out  DATA_W          registered forwarded word
//  valid_out      out  1               Data_Word/grant_vc valid this cycle
// BEHAVIOUR
//  Reset (async, reset==0): grant=0, grant_vc=0, Data_Word=0, valid_out=0, state=IDLE,
//   ptr=N_VC-1 (first search starts at VC0), credit=0, all weight[i]=1 (plain RR).
//  Eligible VC: req[i]==1 && weight[i]!=0.
//  Handshake: at an edge where VC i is selected, grant<=onehot(i), grant_vc<=i,
//   Data_Word<=data_in slice i, valid_out<=1. Latency req/data -> output = 1 cycle.
//   Producer advances its word after seeing grant[i]==1; no other ack.
//  States: IDLE, SERVE.
//   IDLE: no eligible VC -> stay, grant=0, valid_out=0, Data_Word holds last value.
//     Eligible found -> select first eligible from ptr+1 rotating, credit<=weight-1, SERVE.
//   SERVE (current VC c=ptr):
//     credit>0 && c eligible -> re-grant c, credit<=credit-1.
//     else next eligible from c+1 rotating (c itself last) -> grant it, ptr<=it,
//       credit<=weight-1 (a sole eligible VC is re-granted with reload: work-conserving).
//     no eligible VC -> IDLE, outputs as IDLE.
//  req[c] dropping mid-burst ends the burst; remaining credit is discarded.
//  Weight edit: takes effect at the edge it is sampled; affects the next credit load only.
//   Edit of c during its burst does not change credit, except weight 0: c becomes
//   ineligible at once and the burst ends. Edit and reload of same VC at the same edge:
//   reload uses the OLD weight. vc_assign>=N_VC: write ignored.
//  Search wraps modulo N_VC; ptr is VC_W bits, wrap from N_VC-1 to 0 explicit (non-pow2 N_VC).
//  credit is W_WIDTH bits, never underflows (loaded with weight-1, weight>=1 when loaded).
//  Reset mid-burst: all outputs drop to reset values asynchronously; weights revert to 1.
// STRUCTURE
//  wrr_pkg.vh: state encodings (IDLE, SERVE), default weight constant, clog2 function.
//  Sub-module wrr_rr_pick: combinational rotating-priority finder
//   (inputs eligible vector, start index; outputs found flag, index). Instantiated once.
//  Top holds weight register file, ptr, credit, FSM and output registers.
// TESTING
//  1 reset low 2 cycles, req=4'b1111 -> all outputs 0; after release grant_vc seq 0,1,2,3,0...
//  2 weights {3,4,1,2} for VC0..3, all req -> grant_vc period 10: 0,0,0,1,1,1,1,2,3,3.
//  3 req=4'b1010, weights 1 -> grant_vc 1,3,1,3; VC0/VC2 never granted, no idle bubble.
//  4 weight[2]=0, all req -> VC2 skipped; req=4'b0100 only -> valid_out=0, state IDLE.
//  5 VC1 weight 4 mid-burst after 2 grants, edit weight[1]=1 -> burst still 4 long,
//    next VC1 visit 1 long; edit weight[1]=0 mid-burst -> next edge grants VC2.
//  6 reset asserted between edges mid-burst -> grant/valid_out 0 immediately; restart at VC0.

Source files
------------

// File: rtl/wrr_sched_param_pkg.sv
// Shared types and constants for the parametrised weighted-round-robin scheduler.
package wrr_sched_param_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } wrr_state_e;

    // Weight every VC comes out of reset with: plain round-robin.
    localparam int DEFAULT_WEIGHT = 1;

    function automatic int wrr_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_sched_param_rr_pick.sv
// Rotating-priority finder: first set bit of eligible at or after start, wrapping modulo N_VC.
module wrr_sched_param_rr_pick #(
    parameter int N_VC = 4,
    parameter int VC_W = 2
) (
    input  logic [N_VC-1:0] eligible,
    input  logic [VC_W-1:0] start,
    output logic            found,
    output logic [VC_W-1:0] idx
);

    localparam int SW = VC_W + 1;

    logic [SW-1:0] cand_s;

    // Scan from the farthest offset down so the nearest eligible VC is written last.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int k = N_VC - 1; k >= 0; k--) begin
            cand_s = {1'b0, start} + SW'(k);
            cand_s = (cand_s >= SW'(N_VC)) ? (cand_s - SW'(N_VC)) : cand_s;
            found  = found | eligible[cand_s[VC_W-1:0]];
            idx    = eligible[cand_s[VC_W-1:0]] ? cand_s[VC_W-1:0] : idx;
        end
    end

endmodule

// File: rtl/wrr_sched_param.sv
// Weighted-round-robin scheduler: N_VC request/grant channels, one DATA_W word forwarded per cycle.
module wrr_sched_param
    import wrr_sched_param_pkg::*;
#(
    parameter int N_VC    = 4,
    parameter int W_WIDTH = 3,
    parameter int DATA_W  = 4,
    parameter int VC_W    = 2
) (
    input  logic                     CLK_2MHz,
    input  logic                     reset,
    input  logic [N_VC-1:0]          req,
    input  logic [N_VC*DATA_W-1:0]   data_in,
    input  logic                     edit_weight,
    input  logic [VC_W-1:0]          vc_assign,
    input  logic [W_WIDTH-1:0]       weight_assign,
    output logic [N_VC-1:0]          grant,
    output logic [VC_W-1:0]          grant_vc,
    output logic [DATA_W-1:0]        Data_Word,
    output logic                     valid_out
);

    logic [W_WIDTH-1:0] weight_r [N_VC];
    logic [VC_W-1:0]    ptr_r;
    logic [W_WIDTH-1:0] credit_r;
    wrr_state_e         state_r;

    logic [N_VC-1:0]    zero_edit_s;
    logic [N_VC-1:0]    eligible_s;
    logic [VC_W-1:0]    start_s;
    logic               stay_s;
    logic               pick_found_s;
    logic [VC_W-1:0]    pick_idx_s;

    // A weight-0 write disqualifies its VC at the very edge it is sampled; other writes wait a cycle.
    always_comb begin
        zero_edit_s = '0;
        eligible_s  = '0;
        for (int i = 0; i < N_VC; i++) begin
            zero_edit_s[i] = edit_weight && (vc_assign == VC_W'(i))
                             && (weight_assign == {W_WIDTH{1'b0}});
            eligible_s[i]  = req[i] && (weight_r[i] != {W_WIDTH{1'b0}}) && !zero_edit_s[i];
        end
    end

    // Search start is ptr+1 with explicit wrap so non-power-of-two N_VC works.
    always_comb begin
        start_s = '0;
        if (ptr_r == VC_W'(N_VC - 1)) begin
            start_s = '0;
        end else begin
            start_s = ptr_r + VC_W'(1);
        end
        stay_s = (state_r == SERVE) && (credit_r != {W_WIDTH{1'b0}}) && eligible_s[ptr_r];
    end

    wrr_sched_param_rr_pick #(
        .N_VC (N_VC),
        .VC_W (VC_W)
    ) u_pick (
        .eligible (eligible_s),
        .start    (start_s),
        .found    (pick_found_s),
        .idx      (pick_idx_s)
    );

    // Weight register file; indices outside 0..N_VC-1 match no entry and are dropped.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_VC; i++) begin
                weight_r[i] <= W_WIDTH'(DEFAULT_WEIGHT);
            end
        end else begin
            for (int i = 0; i < N_VC; i++) begin
                if (edit_weight && (vc_assign == VC_W'(i))) begin
                    weight_r[i] <= weight_assign;
                end else begin
                    weight_r[i] <= weight_r[i];
                end
            end
        end
    end

    // Scheduler FSM and registered outputs; reloads read the pre-edit weight.
    always_ff @(posedge CLK_2MHz or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            ptr_r     <= VC_W'(N_VC - 1);
            credit_r  <= '0;
            grant     <= '0;
            grant_vc  <= '0;
            Data_Word <= '0;
            valid_out <= 1'b0;
        end else begin
            case (state_r)
                IDLE, SERVE: begin
                    if (stay_s) begin
                        grant     <= {{(N_VC-1){1'b0}}, 1'b1} << ptr_r;
                        grant_vc  <= ptr_r;
                        Data_Word <= data_in[ptr_r*DATA_W +: DATA_W];
                        valid_out <= 1'b1;
                        credit_r  <= credit_r - W_WIDTH'(1);
                        state_r   <= SERVE;
                    end else if (pick_found_s) begin
                        grant     <= {{(N_VC-1){1'b0}}, 1'b1} << pick_idx_s;
                        grant_vc  <= pick_idx_s;
                        Data_Word <= data_in[pick_idx_s*DATA_W +: DATA_W];
                        valid_out <= 1'b1;
                        ptr_r     <= pick_idx_s;
                        credit_r  <= weight_r[pick_idx_s] - W_WIDTH'(1);
                        state_r   <= SERVE;
                    end else begin
                        grant     <= '0;
                        valid_out <= 1'b0;
                        credit_r  <= '0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    grant     <= '0;
                    valid_out <= 1'b0;
                    credit_r  <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_sched_param.sv
// Table-driven bench for wrr_sched_param with a one-cycle-latency expectation scoreboard.
module tb_wrr_sched_param;

    localparam int N_VC    = 4;
    localparam int W_WIDTH = 3;
    localparam int DATA_W  = 4;
    localparam int VC_W    = 2;

    logic                   CLK_2MHz = 1'b0;
    logic                   reset;
    logic [N_VC-1:0]        req;
    logic [N_VC*DATA_W-1:0] data_in;
    logic                   edit_weight;
    logic [VC_W-1:0]        vc_assign;
    logic [W_WIDTH-1:0]     weight_assign;
    logic [N_VC-1:0]        grant;
    logic [VC_W-1:0]        grant_vc;
    logic [DATA_W-1:0]      Data_Word;
    logic                   valid_out;

    int tests = 0;
    int fails = 0;
    int gidx  = 0;

    typedef struct {
        logic [N_VC-1:0]    req;
        logic               edit;
        logic [VC_W-1:0]    vc;
        logic [W_WIDTH-1:0] w;
        logic               ev;
        logic [VC_W-1:0]    evc;
    } vec_t;

    typedef struct {
        logic              ev;
        logic [VC_W-1:0]   evc;
        logic [DATA_W-1:0] edata;
        string             name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    wrr_sched_param #(
        .N_VC    (N_VC),
        .W_WIDTH (W_WIDTH),
        .DATA_W  (DATA_W),
        .VC_W    (VC_W)
    ) dut (
        .CLK_2MHz      (CLK_2MHz),
        .reset         (reset),
        .req           (req),
        .data_in       (data_in),
        .edit_weight   (edit_weight),
        .vc_assign     (vc_assign),
        .weight_assign (weight_assign),
        .grant         (grant),
        .grant_vc      (grant_vc),
        .Data_Word     (Data_Word),
        .valid_out     (valid_out)
    );

    always #5 CLK_2MHz = ~CLK_2MHz;

    function automatic logic [DATA_W-1:0] word(input int idx, input int vc);
        return DATA_W'(idx * 3 + vc * 5);
    endfunction

    function automatic void add(input logic [N_VC-1:0] r, input logic e, input logic [VC_W-1:0] v,
                                input logic [W_WIDTH-1:0] w, input logic ev, input logic [VC_W-1:0] evc);
        vec_t t;
        t.req  = r;
        t.edit = e;
        t.vc   = v;
        t.w    = w;
        t.ev   = ev;
        t.evc  = evc;
        vecs.push_back(t);
    endfunction

    // all VCs requesting, expect grant of evc
    function automatic void g(input logic [VC_W-1:0] evc);
        add(4'b1111, 1'b0, 2'd0, 3'd0, 1'b1, evc);
    endfunction

    // weight write with nobody requesting, expect no output
    function automatic void ed(input logic [VC_W-1:0] v, input logic [W_WIDTH-1:0] w);
        add(4'b0000, 1'b1, v, w, 1'b0, 2'd0);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        logic [N_VC-1:0] eg;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e  = sb.pop_front();
            eg = e.ev ? (4'b0001 << e.evc) : 4'b0000;
            check({e.name, "/valid"}, 32'(valid_out), 32'(e.ev));
            check({e.name, "/grant"}, 32'(grant), 32'(eg));
            if (e.ev) begin
                check({e.name, "/grant_vc"}, 32'(grant_vc), 32'(e.evc));
                check({e.name, "/data"}, 32'(Data_Word), 32'(e.edata));
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        exp_t e;
        req           = v.req;
        edit_weight   = v.edit;
        vc_assign     = v.vc;
        weight_assign = v.w;
        for (int i = 0; i < N_VC; i++) begin
            data_in[i*DATA_W +: DATA_W] = word(gidx, i);
        end
        e.ev    = v.ev;
        e.evc   = v.evc;
        e.edata = word(gidx, int'(v.evc));
        e.name  = nm;
        sb.push_back(e);
        gidx++;
        @(posedge CLK_2MHz);
        #1;
        check_out();
        @(negedge CLK_2MHz);
    endtask

    task automatic run_group(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("%s[%0d]", name, i));
        end
        vecs.delete();
    endtask

    task automatic check_zero(input string name);
        check({name, "/valid"}, 32'(valid_out), 32'd0);
        check({name, "/grant"}, 32'(grant), 32'd0);
        check({name, "/grant_vc"}, 32'(grant_vc), 32'd0);
        check({name, "/data"}, 32'(Data_Word), 32'd0);
    endtask

    // Two reset cycles with every VC requesting, then release on a falling edge.
    task automatic reset_dut(input string name);
        reset         = 1'b0;
        req           = 4'b1111;
        edit_weight   = 1'b0;
        vc_assign     = 2'd0;
        weight_assign = 3'd0;
        data_in       = 16'hFFFF;
        repeat (2) @(posedge CLK_2MHz);
        #1;
        check_zero(name);
        @(negedge CLK_2MHz);
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset state, then plain round-robin
        reset_dut("t1_reset");
        g(2'd0); g(2'd1); g(2'd2); g(2'd3); g(2'd0); g(2'd1);
        run_group("t1_rr");

        // 2: weights {3,4,1,2}
        reset_dut("t2_reset");
        ed(2'd0, 3'd3); ed(2'd1, 3'd4); ed(2'd2, 3'd1); ed(2'd3, 3'd2);
        g(2'd0); g(2'd0); g(2'd0); g(2'd1); g(2'd1); g(2'd1); g(2'd1);
        g(2'd2); g(2'd3); g(2'd3); g(2'd0); g(2'd0);
        run_group("t2_wrr");

        // 3: sparse requests, no idle bubble
        reset_dut("t3_reset");
        for (int i = 0; i < 6; i++) begin
            add(4'b1010, 1'b0, 2'd0, 3'd0, 1'b1, (i % 2 == 0) ? 2'd1 : 2'd3);
        end
        run_group("t3_sparse");

        // 4: weight 0 disables VC2; sole request from a disabled VC idles
        reset_dut("t4_reset");
        ed(2'd2, 3'd0);
        g(2'd0); g(2'd1); g(2'd3); g(2'd0); g(2'd1); g(2'd3);
        add(4'b0100, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
        add(4'b0100, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
        add(4'b0100, 1'b0, 2'd0, 3'd0, 1'b0, 2'd0);
        g(2'd0);
        run_group("t4_disable");

        // 5: mid-burst weight edits and same-edge reload
        reset_dut("t5_reset");
        ed(2'd1, 3'd4);
        g(2'd0); g(2'd1); g(2'd1);
        add(4'b1111, 1'b1, 2'd1, 3'd1, 1'b1, 2'd1);
        g(2'd1); g(2'd2); g(2'd3); g(2'd0); g(2'd1); g(2'd2);
        add(4'b1111, 1'b1, 2'd1, 3'd4, 1'b1, 2'd3);
        g(2'd0); g(2'd1); g(2'd1);
        add(4'b1111, 1'b1, 2'd1, 3'd0, 1'b1, 2'd2);
        g(2'd3); g(2'd0); g(2'd2); g(2'd3);
        add(4'b1111, 1'b1, 2'd0, 3'd3, 1'b1, 2'd0);
        g(2'd2); g(2'd3); g(2'd0); g(2'd0); g(2'd0); g(2'd2);
        run_group("t5_edit");

        // 6: asynchronous reset between edges in the middle of a burst
        reset_dut("t6_reset");
        ed(2'd0, 3'd3);
        g(2'd0); g(2'd0);
        run_group("t6_pre");
        @(posedge CLK_2MHz);
        #2;
        reset = 1'b0;
        #1;
        check_zero("t6_async");
        @(negedge CLK_2MHz);
        @(negedge CLK_2MHz);
        reset = 1'b1;
        g(2'd0); g(2'd1); g(2'd2); g(2'd3);
        run_group("t6_post");

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
